neuron_feeder: RTL and testbench

Sequencer that drives one neuron and collects its result. It buffers an N_IN-word feature vector written by the host, pulses the neuron's reset to align its internal step counter, then streams the vector one word per cycle. After a fixed drain period it captures the neuron's 23-bit activated output and presents it to the host with a one-cycle valid pulse. It sits between the layer controller/host and each neuron instance.

---
 rtl/nn_pkg.sv | 14 +
 rtl/feature_bank.sv | 24 ++
 rtl/neuron_feeder.sv | 155 +++++++++++++++
 tb/tb_neuron_feeder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared constants and the feeder state encoding for the neuron datapath.
package nn_pkg;

  localparam int DATA_W = 12;
  localparam int RES_W  = 23;

  typedef enum logic [1:0] {
    FEED_IDLE   = 2'd0,
    FEED_SYNC   = 2'd1,
    FEED_STREAM = 2'd2,
    FEED_DRAIN  = 2'd3
  } feed_state_e;

endpackage

// File: rtl/feature_bank.sv
// N-entry feature register file: one synchronous write port, one combinational read port.
module feature_bank #(
  parameter int N  = 3,
  parameter int W  = 12,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [N];

  // Contents are deliberately left uncleared by reset; callers range-check addresses.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/neuron_feeder.sv
// Buffers a feature vector, resets and streams it into one neuron, then captures its result.
// Optional FEEDER_PINGPONG_EN: double-buffered feature storage so the host can write while busy.
module neuron_feeder
  import nn_pkg::*;
#(
  parameter int N_IN      = 3,
  parameter int DATA_W    = nn_pkg::DATA_W,
  parameter int RES_W     = nn_pkg::RES_W,
  parameter int DRAIN_CYC = 3,
  localparam int AW       = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  input  logic              start,
  output logic              busy,
  output logic              nrn_rst,
  output logic [DATA_W-1:0] nrn_data,
  output logic              nrn_valid,
  input  logic [RES_W-1:0]  nrn_out,
  output logic [RES_W-1:0]  res_data,
  output logic              res_valid,
  output logic [1:0]        fsm_state
);

  localparam logic [1:0] ST_IDLE   = FEED_IDLE;
  localparam logic [1:0] ST_SYNC   = FEED_SYNC;
  localparam logic [1:0] ST_STREAM = FEED_STREAM;
  localparam logic [1:0] ST_DRAIN  = FEED_DRAIN;

  localparam int CNT_MAX = (N_IN > DRAIN_CYC) ? N_IN : DRAIN_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] LAST_IDX   = CW'(N_IN - 1);
  localparam logic [CW-1:0] LAST_DRAIN = CW'(DRAIN_CYC - 1);

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic              start_ok;
  logic              addr_ok;
  logic              wr_ok;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;

  assign busy      = (state != ST_IDLE);
  assign start_ok  = start && !busy;
  assign addr_ok   = (32'(wr_addr) < 32'(N_IN));
  assign nrn_rst   = rst || (state == ST_SYNC);
  assign fsm_state = state;

`ifdef FEEDER_PINGPONG_EN
  assign wr_ok = wr_en && addr_ok;
`else
  assign wr_ok = wr_en && addr_ok && !busy;
`endif

  // nrn_data is registered, so the bank is read one index ahead of the word on the wire.
  always_comb begin
    rd_addr = '0;
    if (state == ST_STREAM && cnt != LAST_IDX) rd_addr = AW'(cnt + 1'b1);
  end

`ifdef FEEDER_PINGPONG_EN
  logic              host_sel;
  logic [DATA_W-1:0] rd_data0;
  logic [DATA_W-1:0] rd_data1;

  feature_bank #(.N(N_IN), .W(DATA_W), .AW(AW)) u_bank0 (
    .clk   (clk),
    .we    (wr_ok && !host_sel),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data0)
  );

  feature_bank #(.N(N_IN), .W(DATA_W), .AW(AW)) u_bank1 (
    .clk   (clk),
    .we    (wr_ok && host_sel),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data1)
  );

  // The stream bank is always the one the host is not writing.
  assign rd_data = host_sel ? rd_data0 : rd_data1;

  always_ff @(posedge clk) begin
    if (rst)           host_sel <= 1'b0;
    else if (start_ok) host_sel <= ~host_sel;
  end
`else
  feature_bank #(.N(N_IN), .W(DATA_W), .AW(AW)) u_bank (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      nrn_data  <= '0;
      nrn_valid <= 1'b0;
      res_data  <= '0;
      res_valid <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      wr_err    <= wr_en && !wr_ok;
      res_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_SYNC;
        end
        ST_SYNC: begin
          state     <= ST_STREAM;
          cnt       <= '0;
          nrn_data  <= rd_data;
          nrn_valid <= 1'b1;
        end
        ST_STREAM: begin
          if (cnt == LAST_IDX) begin
            state     <= ST_DRAIN;
            cnt       <= '0;
            nrn_data  <= '0;
            nrn_valid <= 1'b0;
          end else begin
            cnt      <= cnt + 1'b1;
            nrn_data <= rd_data;
          end
        end
        ST_DRAIN: begin
          // Drain covers the neuron's sum and ReLU stages before its output is final.
          if (cnt == LAST_DRAIN) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            res_data  <= nrn_out;
            res_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_feeder.sv
// Directed bench for neuron_feeder: reset, framing, back-to-back, write hazards, mid-frame reset.
module tb_neuron_feeder;

`ifdef FEEDER_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SYNC   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [11:0] wr_data;
  logic        wr_err;
  logic        start;
  logic        busy;
  logic        nrn_rst;
  logic [11:0] nrn_data;
  logic        nrn_valid;
  logic [22:0] nrn_out;
  logic [22:0] res_data;
  logic        res_valid;
  logic [1:0]  fsm_state;

  int n_tests;
  int n_fail;

  logic [11:0] bank_m [2][3];
  int          host_m;
  logic [11:0] exp_w [3];

  neuron_feeder dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_err    (wr_err),
    .start     (start),
    .busy      (busy),
    .nrn_rst   (nrn_rst),
    .nrn_data  (nrn_data),
    .nrn_valid (nrn_valid),
    .nrn_out   (nrn_out),
    .res_data  (res_data),
    .res_valid (res_valid),
    .fsm_state (fsm_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bench-side model of the feature storage; returns the expected wr_err.
  function automatic bit model_write(input int a, input logic [11:0] d, input bit busy_m);
    bit ok;
    ok = (a < 3) && (PP || !busy_m);
    if (ok) bank_m[host_m][a] = d;
    return !ok;
  endfunction

  function automatic void model_start();
    int strm;
    if (PP) host_m = host_m ^ 1;
    strm = PP ? (host_m ^ 1) : 0;
    for (int i = 0; i < 3; i++) exp_w[i] = bank_m[strm][i];
  endfunction

  // Driver tasks
  task automatic do_write(input int a, input logic [11:0] d);
    bit exp_err;
    wr_en   = 1'b1;
    wr_addr = 2'(a);
    wr_data = d;
    exp_err = model_write(a, d, 1'b0);
    tick();
    wr_en = 1'b0;
    check("wr_err_idle", {31'd0, wr_err}, {31'd0, exp_err});
    if (exp_err) begin
      tick();
      check("wr_err_pulse_end", {31'd0, wr_err}, 32'd0);
    end
  endtask

  task automatic start_frame(input bit co_wr, input logic [11:0] co_d);
    bit dummy;
    start = 1'b1;
    if (co_wr) begin
      wr_en   = 1'b1;
      wr_addr = 2'd0;
      wr_data = co_d;
      dummy   = model_write(0, co_d, 1'b0);
    end
    model_start();
  endtask

  // Caller has raised start just before edge E0; each step below lands 1ns after edge Ek.
  task automatic frame_body(input logic [22:0] res, input bit chain, input bit ign_start,
                            input bit inj_wr);
    bit exp_err;
    logic [11:0] w0, w1, w2;
    w0 = exp_w[0];
    w1 = exp_w[1];
    w2 = exp_w[2];
    exp_err = 1'b0;
    tick();  // E0
    start = 1'b0;
    wr_en = 1'b0;
    check("sync_busy", {31'd0, busy}, 32'd1);
    check("sync_nrn_rst", {31'd0, nrn_rst}, 32'd1);
    check("sync_state", {30'd0, fsm_state}, {30'd0, S_SYNC});
    check("sync_valid", {31'd0, nrn_valid}, 32'd0);
    tick();  // E1
    check("w0_nrn_rst", {31'd0, nrn_rst}, 32'd0);
    check("w0_valid", {31'd0, nrn_valid}, 32'd1);
    check("w0_data", {20'd0, nrn_data}, {20'd0, w0});
    if (inj_wr) begin
      wr_en   = 1'b1;
      wr_addr = 2'd2;
      wr_data = 12'hFFF;
      exp_err = model_write(2, 12'hFFF, 1'b1);
    end
    tick();  // E2
    check("w1_data", {20'd0, nrn_data}, {20'd0, w1});
    if (inj_wr) begin
      wr_en = 1'b0;
      check("busy_wr_err", {31'd0, wr_err}, {31'd0, exp_err});
    end
    if (ign_start) start = 1'b1;
    tick();  // E3
    start = 1'b0;
    check("w2_data", {20'd0, nrn_data}, {20'd0, w2});
    check("w2_valid", {31'd0, nrn_valid}, 32'd1);
    tick();  // E4
    check("drain_valid", {31'd0, nrn_valid}, 32'd0);
    check("drain_data", {20'd0, nrn_data}, 32'd0);
    check("drain_state", {30'd0, fsm_state}, {30'd0, S_DRAIN});
    nrn_out = ~res;
    tick();  // E5
    tick();  // E6
    check("pre_res_valid", {31'd0, res_valid}, 32'd0);
    check("pre_busy", {31'd0, busy}, 32'd1);
    nrn_out = res;
    tick();  // E7
    check("res_valid", {31'd0, res_valid}, 32'd1);
    check("res_data", {9'd0, res_data}, {9'd0, res});
    check("res_busy", {31'd0, busy}, 32'd0);
    nrn_out = 23'h0F0F0F;
    if (chain) begin
      start_frame(1'b0, 12'h000);
    end else begin
      tick();  // E8
      check("post_res_valid", {31'd0, res_valid}, 32'd0);
      check("post_res_hold", {9'd0, res_data}, {9'd0, res});
      check("post_busy", {31'd0, busy}, 32'd0);
      check("post_state", {30'd0, fsm_state}, {30'd0, S_IDLE});
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    host_m  = 0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 3; i++) bank_m[b][i] = 'x;
    rst     = 1'b1;
    start   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = 2'd0;
    wr_data = 12'd0;
    nrn_out = 23'd0;

    // Reset and idle
    repeat (2) begin
      tick();
      check("rst_nrn_rst", {31'd0, nrn_rst}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_nrn_valid", {31'd0, nrn_valid}, 32'd0);
      check("rst_nrn_data", {20'd0, nrn_data}, 32'd0);
      check("rst_res_valid", {31'd0, res_valid}, 32'd0);
      check("rst_res_data", {9'd0, res_data}, 32'd0);
      check("rst_wr_err", {31'd0, wr_err}, 32'd0);
    end
    rst = 1'b0;
    tick();
    check("idle_nrn_rst", {31'd0, nrn_rst}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_state", {30'd0, fsm_state}, {30'd0, S_IDLE});

    // Load vector, then an out-of-range write that must be rejected
    do_write(0, 12'h010);
    do_write(1, 12'h020);
    do_write(2, 12'h030);
    do_write(3, 12'h555);

    // Basic frame chained into a second frame (ignored start + busy write inside)
    start_frame(1'b0, 12'h000);
    frame_body(23'h123456, 1'b1, 1'b0, 1'b0);
    frame_body(23'h7ABCDE, 1'b0, 1'b1, 1'b1);

    // Coincident start and write to addr 0
    tick();
    start_frame(1'b1, 12'hABC);
    frame_body(23'h000001, 1'b0, 1'b0, 1'b0);

    // Mid-frame reset
    tick();
    start_frame(1'b0, 12'h000);
    tick();  // E0
    start = 1'b0;
    wr_en = 1'b0;
    tick();  // E1
    tick();  // E2
    check("mid_state", {30'd0, fsm_state}, {30'd0, S_STREAM});
    rst = 1'b1;
    tick();
    host_m = 0;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_nrn_rst", {31'd0, nrn_rst}, 32'd1);
    check("mid_rst_res_data", {9'd0, res_data}, 32'd0);
    check("mid_rst_nrn_valid", {31'd0, nrn_valid}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("mid_no_res_valid", {31'd0, res_valid}, 32'd0);
    end
    check("mid_idle_busy", {31'd0, busy}, 32'd0);
    check("mid_res_data_held", {9'd0, res_data}, 32'd0);

    // Fresh vector and a normal frame after the reset
    do_write(0, 12'h111);
    do_write(1, 12'h222);
    do_write(2, 12'h333);
    start_frame(1'b0, 12'h000);
    frame_body(23'h2AAAAA, 1'b0, 1'b0, 1'b0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
